gpio_input_filter: RTL and testbench

Per-pin input conditioning stage between the chip pads and the GPIO peripheral's `gpio_in` port. It synchronises up to 32 asynchronous pad inputs and can debounce each pin with a shared prescaled sample tick and a per-pin stability counter. It delivers a clean level vector `gpio_filt` to the peripheral and a one-cycle per-pin change pulse. Configuration inputs come from the SoC control registers and are quasi-static.

---
 rtl/gpio_input_filter_if.sv | 25 ++
 rtl/gpio_input_filter.sv | 97 +++++++++
 tb/tb_gpio_input_filter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_input_filter_if.sv
// Signal bundle between the pad-side input conditioning stage and the GPIO peripheral.
// The master side drives pads and configuration, and the slave side is the filter.
interface gpio_input_filter_if #(
  parameter int NUM_GPIO    = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16
);
  logic [NUM_GPIO-1:0]    pad_in;
  logic [NUM_GPIO-1:0]    filt_en;
  logic [PRESC_WIDTH-1:0] presc_div;
  logic [CNT_WIDTH-1:0]   filt_thresh;
  logic [NUM_GPIO-1:0]    gpio_filt;
  logic [NUM_GPIO-1:0]    gpio_chg;
  logic                   sample_tick;

  modport master (
    output pad_in, filt_en, presc_div, filt_thresh,
    input  gpio_filt, gpio_chg, sample_tick
  );

  modport slave (
    input  pad_in, filt_en, presc_div, filt_thresh,
    output gpio_filt, gpio_chg, sample_tick
  );
endinterface

// File: rtl/gpio_input_filter.sv
// Per-pin pad synchroniser with optional debounce driven by a shared prescaled sample tick,
// producing a clean level vector and a one-cycle change pulse per pin.
module gpio_input_filter #(
  parameter int NUM_GPIO    = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  gpio_input_filter_if.slave  bus
);

  logic [NUM_GPIO-1:0]    r_sync0;
  logic [NUM_GPIO-1:0]    r_sync1;
  logic [NUM_GPIO-1:0]    s_sync;
  logic [NUM_GPIO-1:0]    r_filt;
  logic [NUM_GPIO-1:0]    r_filt_d;
  logic [NUM_GPIO-1:0]    filt_next;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic                   tick;
  logic [CNT_WIDTH-1:0]   r_cnt    [NUM_GPIO];
  logic [CNT_WIDTH-1:0]   cnt_next [NUM_GPIO];
  logic [CNT_WIDTH:0]     thresh_eff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= bus.pad_in;
      r_sync1 <= r_sync0;
    end
  end

  assign s_sync = r_sync1;

  // Tick is held low in reset so nothing is evaluated before the counter runs.
  assign tick = ~HRESET & (r_presc >= bus.presc_div);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_presc <= '0;
    end else if (tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_WIDTH'(1);
    end
  end

  // One extra bit on the compare so a saturated counter still reaches the threshold.
  assign thresh_eff = (bus.filt_thresh == '0) ? (CNT_WIDTH+1)'(1)
                                              : {1'b0, bus.filt_thresh};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_GPIO; i++) begin
      filt_next[i] = r_filt[i];
      cnt_next[i]  = r_cnt[i];
      if (!bus.filt_en[i]) begin
        filt_next[i] = s_sync[i];
        cnt_next[i]  = '0;
      end else if (tick) begin
        if (s_sync[i] == r_filt[i]) begin
          cnt_next[i] = '0;
        end else if (({1'b0, r_cnt[i]} + (CNT_WIDTH+1)'(1)) >= thresh_eff) begin
          filt_next[i] = s_sync[i];
          cnt_next[i]  = '0;
        end else begin
          cnt_next[i] = r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // NOTE: the counter array is per-pin flops rather than RAM, so it is reset with everything else.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_filt   <= '0;
      r_filt_d <= '0;
      for (int i = 0; i < NUM_GPIO; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_filt   <= filt_next;
      r_filt_d <= r_filt;
      for (int i = 0; i < NUM_GPIO; i++) begin
        r_cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.gpio_filt   = r_filt;
  assign bus.gpio_chg    = r_filt ^ r_filt_d;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter: directed scenarios plus random pad activity,
// with a cycle-level reference model feeding a scoreboard that a negedge monitor drains.
module tb_gpio_input_filter;
  localparam int N  = 32;
  localparam int CW = 8;
  localparam int PW = 16;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;

  gpio_input_filter_if #(.NUM_GPIO(N), .CNT_WIDTH(CW), .PRESC_WIDTH(PW)) bus ();

  gpio_input_filter #(.NUM_GPIO(N), .CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [N-1:0] filt;
    logic [N-1:0] chg;
    int           presc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: pads reach the filter two edges late; a filtered pin flips once it
  // has seen max(T,1) consecutive ticks whose sample disagrees with the current level.
  logic [N-1:0] pad_hist[$];
  logic [N-1:0] m_level;
  int           m_streak[N];
  int           m_since;

  always @(posedge HCLK or posedge HRESET) begin : model
    exp_t         e;
    logic [N-1:0] s;
    logic [N-1:0] prev;
    bit           tk;
    int           t;
    if (HRESET) begin
      pad_hist.delete();
      m_level = '0;
      m_since = 0;
      foreach (m_streak[i]) m_streak[i] = 0;
      sb_q.delete();
      e.filt  = '0;
      e.chg   = '0;
      e.presc = 0;
      sb_q.push_back(e);
    end else begin
      s  = (pad_hist.size() == 2) ? pad_hist[0] : '0;
      pad_hist.push_back(bus.pad_in);
      if (pad_hist.size() > 2) void'(pad_hist.pop_front());
      tk = (m_since >= int'(bus.presc_div));
      m_since = tk ? 0 : m_since + 1;
      t = (bus.filt_thresh == 0) ? 1 : int'(bus.filt_thresh);
      prev = m_level;
      for (int i = 0; i < N; i++) begin
        if (!bus.filt_en[i]) begin
          m_level[i]  = s[i];
          m_streak[i] = 0;
        end else if (tk) begin
          if (s[i] == m_level[i]) begin
            m_streak[i] = 0;
          end else if (m_streak[i] + 1 >= t) begin
            m_level[i]  = s[i];
            m_streak[i] = 0;
          end else begin
            m_streak[i]++;
          end
        end
      end
      e.filt  = m_level;
      e.chg   = m_level ^ prev;
      e.presc = m_since;
      sb_q.push_back(e);
    end
  end

  always @(negedge HCLK) begin : monitor
    exp_t e;
    logic exp_tick;
    if (sb_q.size() == 0) begin
      if (!HRESET) check("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      exp_tick = !HRESET && (e.presc >= int'(bus.presc_div));
      check("sb_filt", bus.gpio_filt, e.filt);
      check("sb_chg",  bus.gpio_chg,  e.chg);
      check("sb_tick", {{(N-1){1'b0}}, bus.sample_tick}, {{(N-1){1'b0}}, exp_tick});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    bit seen;
    logic [N-1:0] mask;

    bus.pad_in      = '1;
    bus.filt_en     = '0;
    bus.presc_div   = '0;
    bus.filt_thresh = '0;
    HRESET          = 1'b1;

    // Reset with all pads high, then release
    cyc(3);
    check("rst_filt", bus.gpio_filt, '0);
    check("rst_chg",  bus.gpio_chg,  '0);
    check("rst_tick", {31'b0, bus.sample_tick}, '0);
    HRESET = 1'b0;
    cyc(2);
    check("rel_filt_e2", bus.gpio_filt, '0);
    cyc(1);
    check("rel_filt_e3", bus.gpio_filt, '1);
    check("rel_chg_e3",  bus.gpio_chg,  '1);
    cyc(1);
    check("rel_chg_e4",  bus.gpio_chg,  '0);

    // Bypass latency on pin 5
    bus.pad_in = '0;
    cyc(5);
    bus.pad_in[5] = 1'b1;
    cyc(2);
    check("byp_filt_e1", bus.gpio_filt, '0);
    cyc(1);
    check("byp_filt_e2", bus.gpio_filt, 32'h0000_0020);
    check("byp_chg_e2",  bus.gpio_chg,  32'h0000_0020);
    cyc(1);
    check("byp_chg_e3",  bus.gpio_chg,  '0);

    // Debounce accept on pin 0, P=3 T=4
    bus.pad_in      = '0;
    bus.filt_en     = 32'h0000_0001;
    bus.presc_div   = 16'd3;
    bus.filt_thresh = 8'd4;
    cyc(8);
    bus.pad_in[0] = 1'b1;
    k = 0;
    seen = 0;
    while (k < 30 && !seen) begin
      cyc(1);
      k++;
      seen = bus.gpio_filt[0];
    end
    check("deb_seen", {31'b0, seen}, 32'd1);
    check("deb_latency_ok", {31'b0, (k >= 15 && k <= 18)}, 32'd1);

    // Glitch reject: pin 0 back to 0, then a 10-cycle pulse
    bus.pad_in[0] = 1'b0;
    cyc(30);
    check("gl_pre", {31'b0, bus.gpio_filt[0]}, 32'd0);
    bus.pad_in[0] = 1'b1;
    cyc(10);
    bus.pad_in[0] = 1'b0;
    cyc(30);
    check("gl_post", {31'b0, bus.gpio_filt[0]}, 32'd0);

    // Threshold 0 acts as 1 with P=0, pin 1
    bus.filt_en     = 32'h0000_0003;
    bus.presc_div   = 16'd0;
    bus.filt_thresh = 8'd0;
    cyc(5);
    bus.pad_in[1] = 1'b1;
    cyc(2);
    check("t0_filt_e1", {31'b0, bus.gpio_filt[1]}, 32'd0);
    cyc(1);
    check("t0_filt_e2", {31'b0, bus.gpio_filt[1]}, 32'd1);

    // Lower threshold 200 -> 5 while the counter sits at 50
    bus.filt_thresh = 8'd200;
    cyc(3);
    bus.pad_in[1] = 1'b0;
    cyc(52);
    check("thr_hold", {31'b0, bus.gpio_filt[1]}, 32'd1);
    bus.filt_thresh = 8'd5;
    cyc(1);
    check("thr_flip", {31'b0, bus.gpio_filt[1]}, 32'd0);

    // Lower prescaler 1000 -> 2 mid-count
    bus.presc_div = 16'd1000;
    k = 0;
    seen = 0;
    while (k < 1100 && !seen) begin
      cyc(1);
      k++;
      seen = bus.sample_tick;
    end
    check("presc_tick_seen", {31'b0, seen}, 32'd1);
    cyc(500);
    bus.presc_div = 16'd2;
    #1;
    check("presc_now",  {31'b0, bus.sample_tick}, 32'd1);
    cyc(1);
    check("presc_p1",   {31'b0, bus.sample_tick}, 32'd0);
    cyc(1);
    check("presc_p2",   {31'b0, bus.sample_tick}, 32'd0);
    cyc(1);
    check("presc_p3",   {31'b0, bus.sample_tick}, 32'd1);

    // Mixed pins: 0-15 filtered T=2, 16-31 bypassed
    bus.filt_en     = 32'h0000_FFFF;
    bus.presc_div   = 16'd0;
    bus.filt_thresh = 8'd2;
    bus.pad_in      = '0;
    cyc(10);
    bus.pad_in = '1;
    cyc(2);
    check("mix_e1",     bus.gpio_filt, '0);
    cyc(1);
    check("mix_e2",     bus.gpio_filt, 32'hFFFF_0000);
    check("mix_chg_e2", bus.gpio_chg,  32'hFFFF_0000);
    cyc(1);
    check("mix_e3",     bus.gpio_filt, '1);
    check("mix_chg_e3", bus.gpio_chg,  32'h0000_FFFF);
    cyc(1);
    check("mix_chg_e4", bus.gpio_chg,  '0);

    // Asynchronous reset in the middle of a count
    bus.filt_en     = '1;
    bus.filt_thresh = 8'd200;
    bus.pad_in      = '0;
    cyc(10);
    @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    check("arst_filt", bus.gpio_filt, '0);
    check("arst_chg",  bus.gpio_chg,  '0);
    check("arst_tick", {31'b0, bus.sample_tick}, '0);
    cyc(2);
    HRESET = 1'b0;

    // Random pad activity with changing configuration
    for (int r = 0; r < 40; r++) begin
      bus.filt_en     = $urandom;
      bus.presc_div   = PW'($urandom_range(0, 3));
      bus.filt_thresh = CW'($urandom_range(0, 4));
      for (int c = 0; c < 50; c++) begin
        mask = $urandom & $urandom & $urandom;
        bus.pad_in = bus.pad_in ^ mask;
        cyc(1);
      end
    end

    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
